// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline controller: FSM state encoding,
// default geometry and a stage-range helper used to build stall/flush masks.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic [1:0] ST_RUN    = RUN;
    localparam logic [1:0] ST_DRAIN  = DRAIN;
    localparam logic [1:0] ST_HALTED = HALTED;

    localparam int DEF_NUM_STAGES   = 5;
    localparam int DEF_HAZARD_STAGE = 1;
    localparam int DEF_EXEC_STAGE   = 2;
    localparam int DEF_CNT_W        = 32;

    function automatic bit in_range(input int idx, input int lo, input int hi);
        return (idx >= lo) && (idx <= hi);
    endfunction

endpackage

// File: rtl/pipeline_controller_perf_counter.sv
// Clearable event counter; wraps modulo 2^CNT_W when WRAP is set, otherwise
// saturates at all ones. Clear has priority over a same-cycle increment.
module perf_counter #(
    parameter int CNT_W = 32,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            if (WRAP || (count_q != '1)) begin
                count_d = count_q + ONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline hazard/flush controller with a RUN/DRAIN/HALTED debug FSM and four
// performance counters.
module pipeline_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES   = DEF_NUM_STAGES,
    parameter int HAZARD_STAGE = DEF_HAZARD_STAGE,
    parameter int EXEC_STAGE   = DEF_EXEC_STAGE,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  halt_i,
    input  logic                  resume_i,
    input  logic                  dataHazard_i,
    input  logic                  busy_i,
    input  logic                  correctPC_i,
    input  logic [NUM_STAGES-1:0] stageValid_i,
    input  logic                  retire_i,
    input  logic                  clear_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic [1:0]            state_o,
    output logic                  halted_o,
    output logic [CNT_W-1:0]      cycleCnt_o,
    output logic [CNT_W-1:0]      stallCnt_o,
    output logic [CNT_W-1:0]      flushCnt_o,
    output logic [CNT_W-1:0]      retireCnt_o
);

    logic [NUM_STAGES-1:0] busy_stall_mask;
    logic [NUM_STAGES-1:0] cpc_flush_mask;
    logic [NUM_STAGES-1:0] haz_stall_mask;
    logic [NUM_STAGES-1:0] haz_flush_mask;
    logic [NUM_STAGES-1:0] drain_flush_mask;
    logic [NUM_STAGES-1:0] tail_mask;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_masks
            assign busy_stall_mask[gi]  = in_range(gi, 0, EXEC_STAGE);
            assign cpc_flush_mask[gi]   = in_range(gi, 1, EXEC_STAGE);
            assign haz_stall_mask[gi]   = in_range(gi, 0, HAZARD_STAGE);
            assign haz_flush_mask[gi]   = (gi == HAZARD_STAGE + 1);
            assign drain_flush_mask[gi] = (gi == EXEC_STAGE + 1);
            assign tail_mask[gi]        = in_range(gi, EXEC_STAGE + 1, NUM_STAGES - 1);
        end
    endgenerate

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       halted_q;
    logic       halted_d;
    logic       tail_busy;

    // Anything still live beyond EXEC_STAGE must retire before we can halt.
    assign tail_busy = |(stageValid_i & tail_mask);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (halt_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!tail_busy) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (resume_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    logic [NUM_STAGES-1:0] stall_raw;
    logic [NUM_STAGES-1:0] flush_raw;

    always_comb begin
        stall_raw = '0;
        flush_raw = '0;
        case (state_q)
            ST_RUN: begin
                if (busy_i) begin
                    stall_raw = busy_stall_mask;
                end else if (correctPC_i) begin
                    flush_raw = cpc_flush_mask;
                end else if (dataHazard_i) begin
                    stall_raw = haz_stall_mask;
                    flush_raw = haz_flush_mask;
                end
            end
            ST_DRAIN: begin
                // Freeze the front end and bubble the stage after EXEC so the tail empties.
                stall_raw = busy_stall_mask;
                flush_raw = drain_flush_mask;
            end
            ST_HALTED: begin
                stall_raw = '1;
            end
            default: begin
                stall_raw = '0;
                flush_raw = '0;
            end
        endcase
    end

    assign stall_o  = reset_i ? '0 : stall_raw;
    assign flush_o  = reset_i ? '1 : flush_raw;
    assign state_o  = state_q;
    assign halted_o = halted_q;

    logic             in_run;
    logic [3:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [4];

    assign in_run     = (state_q == ST_RUN);
    assign cnt_inc[0] = (state_q != ST_HALTED);
    assign cnt_inc[1] = in_run && stall_raw[0];
    assign cnt_inc[2] = in_run && correctPC_i && !busy_i;
    assign cnt_inc[3] = retire_i;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_counters
            perf_counter #(
                .CNT_W (CNT_W),
                .WRAP  (1'b1)
            ) u_cnt (
                .clk_i   (clk_i),
                .rst_i   (reset_i),
                .inc_i   (cnt_inc[gi]),
                .clr_i   (clear_i),
                .count_o (cnt_val[gi])
            );
        end
    endgenerate

    assign cycleCnt_o  = cnt_val[0];
    assign stallCnt_o  = cnt_val[1];
    assign flushCnt_o  = cnt_val[2];
    assign retireCnt_o = cnt_val[3];

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench: stimulus pushes hand-computed expectations into a queue and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_controller;

    logic       clk;
    logic       reset_i = 1'b1;
    logic       halt_i = 1'b0;
    logic       resume_i = 1'b0;
    logic       dataHazard_i = 1'b0;
    logic       busy_i = 1'b0;
    logic       correctPC_i = 1'b0;
    logic [4:0] stageValid_i = 5'b0;
    logic       retire_i = 1'b0;
    logic       clear_i = 1'b0;

    logic [4:0]  stall_o;
    logic [4:0]  flush_o;
    logic [1:0]  state_o;
    logic        halted_o;
    logic [31:0] cycle_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] retire_cnt;

    pipeline_controller #(
        .NUM_STAGES   (5),
        .HAZARD_STAGE (1),
        .EXEC_STAGE   (2),
        .CNT_W        (32)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .halt_i       (halt_i),
        .resume_i     (resume_i),
        .dataHazard_i (dataHazard_i),
        .busy_i       (busy_i),
        .correctPC_i  (correctPC_i),
        .stageValid_i (stageValid_i),
        .retire_i     (retire_i),
        .clear_i      (clear_i),
        .stall_o      (stall_o),
        .flush_o      (flush_o),
        .state_o      (state_o),
        .halted_o     (halted_o),
        .cycleCnt_o   (cycle_cnt),
        .stallCnt_o   (stall_cnt),
        .flushCnt_o   (flush_cnt),
        .retireCnt_o  (retire_cnt)
    );

    // Narrow-counter instance for the wrap test.
    logic       retire4 = 1'b0;
    logic       clear4 = 1'b0;
    logic       zero4 = 1'b0;
    logic [4:0] sv4 = 5'b0;
    logic [4:0] stall4;
    logic [4:0] flush4;
    logic [1:0] state4;
    logic       halted4;
    logic [3:0] cyc4;
    logic [3:0] stc4;
    logic [3:0] flc4;
    logic [3:0] ret4;

    pipeline_controller #(
        .NUM_STAGES   (5),
        .HAZARD_STAGE (1),
        .EXEC_STAGE   (2),
        .CNT_W        (4)
    ) dut4 (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .halt_i       (zero4),
        .resume_i     (zero4),
        .dataHazard_i (zero4),
        .busy_i       (zero4),
        .correctPC_i  (zero4),
        .stageValid_i (sv4),
        .retire_i     (retire4),
        .clear_i      (clear4),
        .stall_o      (stall4),
        .flush_o      (flush4),
        .state_o      (state4),
        .halted_o     (halted4),
        .cycleCnt_o   (cyc4),
        .stallCnt_o   (stc4),
        .flushCnt_o   (flc4),
        .retireCnt_o  (ret4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_STALL = 0;
    localparam int S_FLUSH = 1;
    localparam int S_STATE = 2;
    localparam int S_HALT  = 3;
    localparam int S_CYC   = 4;
    localparam int S_STC   = 5;
    localparam int S_FLC   = 6;
    localparam int S_RET   = 7;
    localparam int S_RET4  = 8;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_STALL: return 32'(stall_o);
            S_FLUSH: return 32'(flush_o);
            S_STATE: return 32'(state_o);
            S_HALT:  return 32'(halted_o);
            S_CYC:   return cycle_cnt;
            S_STC:   return stall_cnt;
            S_FLC:   return flush_cnt;
            S_RET:   return retire_cnt;
            S_RET4:  return 32'(ret4);
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = actual(e.sel);
                n_tests++;
                if (a !== e.exp) begin
                    n_fail++;
                    $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, a, e.exp, $time);
                end else begin
                    $display("[TB] ok %s = 0x%0h at %0t", e.name, a, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Reset state
        step();
        step();
        expect_val("rst_state", S_STATE, 32'd0);
        expect_val("rst_halted", S_HALT, 32'd0);
        expect_val("rst_stall", S_STALL, 32'h00);
        expect_val("rst_flush", S_FLUSH, 32'h1f);
        expect_val("rst_cyc", S_CYC, 32'd0);
        expect_val("rst_ret4", S_RET4, 32'd0);
        step();
        reset_i = 1'b0;
        do_clear();

        // busy for three cycles
        busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_val("busy_stall", S_STALL, 32'h07);
            expect_val("busy_flush", S_FLUSH, 32'h00);
            step();
        end
        busy_i = 1'b0;
        expect_val("busy_stallcnt", S_STC, 32'd3);
        expect_val("busy_cyccnt", S_CYC, 32'd3);
        expect_val("idle_stall", S_STALL, 32'h00);
        expect_val("idle_flush", S_FLUSH, 32'h00);

        // correctPC beats hazard, then hazard alone
        do_clear();
        dataHazard_i = 1'b1;
        correctPC_i  = 1'b1;
        expect_val("cpc_stall", S_STALL, 32'h00);
        expect_val("cpc_flush", S_FLUSH, 32'h06);
        step();
        correctPC_i = 1'b0;
        expect_val("cpc_flushcnt", S_FLC, 32'd1);
        expect_val("haz_stall", S_STALL, 32'h03);
        expect_val("haz_flush", S_FLUSH, 32'h04);
        step();
        dataHazard_i = 1'b0;
        expect_val("haz_stallcnt", S_STC, 32'd1);
        expect_val("haz_flushcnt", S_FLC, 32'd1);

        // halt (with same-cycle correctPC) -> drain -> halted -> resume
        do_clear();
        halt_i       = 1'b1;
        correctPC_i  = 1'b1;
        stageValid_i = 5'b11000;
        expect_val("halt_cpc_flush", S_FLUSH, 32'h06);
        expect_val("halt_cpc_state", S_STATE, 32'd0);
        step();
        halt_i       = 1'b0;
        correctPC_i  = 1'b0;
        dataHazard_i = 1'b1;
        resume_i     = 1'b1;
        expect_val("drain1_state", S_STATE, 32'd1);
        expect_val("drain1_stall", S_STALL, 32'h07);
        expect_val("drain1_flush", S_FLUSH, 32'h08);
        expect_val("drain1_halted", S_HALT, 32'd0);
        expect_val("drain1_flushcnt", S_FLC, 32'd1);
        expect_val("drain1_cyc", S_CYC, 32'd1);
        step();
        stageValid_i = 5'b00000;
        resume_i     = 1'b0;
        expect_val("drain2_state", S_STATE, 32'd1);
        expect_val("drain2_stall", S_STALL, 32'h07);
        expect_val("drain2_flush", S_FLUSH, 32'h08);
        expect_val("drain2_cyc", S_CYC, 32'd2);
        expect_val("drain2_stallcnt", S_STC, 32'd0);
        step();
        dataHazard_i = 1'b0;
        halt_i       = 1'b1;
        retire_i     = 1'b1;
        expect_val("halted_state", S_STATE, 32'd2);
        expect_val("halted_flag", S_HALT, 32'd1);
        expect_val("halted_stall", S_STALL, 32'h1f);
        expect_val("halted_flush", S_FLUSH, 32'h00);
        expect_val("halted_cyc", S_CYC, 32'd3);
        step();
        halt_i   = 1'b0;
        retire_i = 1'b0;
        resume_i = 1'b1;
        expect_val("halted_cyc_frozen", S_CYC, 32'd3);
        expect_val("halted_retire", S_RET, 32'd1);
        expect_val("halted_state2", S_STATE, 32'd2);
        step();
        resume_i = 1'b0;
        expect_val("resume_state", S_STATE, 32'd0);
        expect_val("resume_halted", S_HALT, 32'd0);
        expect_val("resume_cyc", S_CYC, 32'd3);
        expect_val("resume_stall", S_STALL, 32'h00);

        // 4-bit retire counter wrap and clear priority
        retire4 = 1'b1;
        repeat (15) step();
        expect_val("ret4_15", S_RET4, 32'd15);
        step();
        retire4 = 1'b0;
        expect_val("ret4_wrap", S_RET4, 32'd0);
        step();
        retire4 = 1'b1;
        step();
        clear4 = 1'b1;
        expect_val("ret4_one", S_RET4, 32'd1);
        step();
        retire4 = 1'b0;
        clear4  = 1'b0;
        expect_val("ret4_clear", S_RET4, 32'd0);

        // reset in DRAIN with counters nonzero
        do_clear();
        halt_i       = 1'b1;
        stageValid_i = 5'b11000;
        retire_i     = 1'b1;
        step();
        halt_i   = 1'b0;
        retire_i = 1'b0;
        expect_val("pre_rst_state", S_STATE, 32'd1);
        expect_val("pre_rst_ret", S_RET, 32'd1);
        expect_val("pre_rst_cyc", S_CYC, 32'd1);
        @(negedge clk);
        #1;
        reset_i = 1'b1;
        expect_val("mid_rst_state", S_STATE, 32'd0);
        expect_val("mid_rst_halted", S_HALT, 32'd0);
        expect_val("mid_rst_stall", S_STALL, 32'h00);
        expect_val("mid_rst_flush", S_FLUSH, 32'h1f);
        expect_val("mid_rst_cyc", S_CYC, 32'd0);
        expect_val("mid_rst_ret", S_RET, 32'd0);
        step();
        expect_val("hold_rst_state", S_STATE, 32'd0);
        expect_val("hold_rst_flush", S_FLUSH, 32'h1f);
        step();
        reset_i      = 1'b0;
        stageValid_i = 5'b00000;
        expect_val("post_rst_state", S_STATE, 32'd0);
        expect_val("post_rst_stall", S_STALL, 32'h00);
        expect_val("post_rst_flush", S_FLUSH, 32'h00);

        step();
        @(negedge clk);
        #1;
        n_tests++;
        if (state_o !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL final_state: got 0x%0h expected 0x0 at %0t", state_o, $time);
        end else begin
            $display("[TB] ok final_state = 0x%0h at %0t", state_o, $time);
        end
        n_tests++;
        if (stall_o !== 5'h00) begin
            n_fail++;
            $display("[TB] FAIL final_stall: got 0x%0h expected 0x0 at %0t", stall_o, $time);
        end else begin
            $display("[TB] ok final_stall = 0x%0h at %0t", stall_o, $time);
        end
        n_tests++;
        if (flush_o !== 5'h00) begin
            n_fail++;
            $display("[TB] FAIL final_flush: got 0x%0h expected 0x0 at %0t", flush_o, $time);
        end else begin
            $display("[TB] ok final_flush = 0x%0h at %0t", flush_o, $time);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
